// File: rtl/nw_pkg.sv
// ---------------------------------------------------------------------------
// nw_pkg
// Shared definitions for the Needleman-Wunsch score-matrix store:
//   - default score width and gap penalty
//   - init FSM state encoding
//   - (x,y) -> linear address mapping, row-major with row length LEN_A+1
//   - static check that the largest gap penalty fits the score width
// ---------------------------------------------------------------------------
package nw_pkg;

  localparam int W_DEF   = 9;
  localparam int GAP_DEF = -1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } init_state_e;

  // Linear address of cell (x,y) in a matrix whose rows are row_len wide.
  function automatic logic [31:0] cell_addr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] row_len);
    return x + (row_len * y);
  endfunction

  // True when max(len_a,len_b)*|gap| is representable in w signed bits.
  // A negative gap may reach -2**(w-1); a positive one only 2**(w-1)-1.
  function automatic bit gap_fits(input int len_a, input int len_b,
                                  input int gap, input int w);
    longint mx;
    longint mag;
    longint lim;
    mx  = longint'((len_a > len_b) ? len_a : len_b);
    mag = (gap < 0) ? -longint'(gap) : longint'(gap);
    lim = (gap < 0) ? (64'sd1 <<< (w - 1)) : ((64'sd1 <<< (w - 1)) - 64'sd1);
    return (mx * mag) <= lim;
  endfunction

endpackage

// File: rtl/score_init_chk.sv
// ---------------------------------------------------------------------------
// score_init_chk
// Simulation-only checker: flags a configuration in which the gap penalty
// accumulator would wrap while filling row/column 0.
// Ports:
//   clk_i   clock
//   busy_i  fill in progress (check is evaluated while filling)
// ---------------------------------------------------------------------------
module score_init_chk
  import nw_pkg::*;
#(
  parameter int LEN_A = 128,
  parameter int LEN_B = 128,
  parameter int W     = W_DEF,
  parameter int GAP   = GAP_DEF
) (
  input logic clk_i,
  input logic busy_i
);

  localparam bit FITS = gap_fits(LEN_A, LEN_B, GAP, W);

  // Overflow check on every fill cycle.
  always @(posedge clk_i) begin
    if (busy_i) begin
      assert (FITS)
        else $error("score_init_chk: max(LEN_A,LEN_B)*|GAP| exceeds %0d-bit signed range", W);
    end
  end

endmodule

// File: rtl/score_init_seq.sv
// ---------------------------------------------------------------------------
// score_init_seq
// Gap row/column fill sequencer. On init_start writes cell (k,0)=k*GAP for
// k=0..LEN_A, then (0,k)=k*GAP for k=1..LEN_B, one cell per cycle. The
// penalty comes from a running accumulator (add GAP per cell, wraps).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   init_start_i    start pulse (ignored while filling)
//   busy_o          fill running (registered)
//   done_o          fill finished, until next start or reset (registered)
//   we_o            memory write enable for the fill
//   waddr_o         linear write address
//   wdata_o         penalty value to write
// ---------------------------------------------------------------------------
module score_init_seq
  import nw_pkg::*;
#(
  parameter int LEN_A = 128,
  parameter int LEN_B = 128,
  parameter int W     = W_DEF,
  parameter int GAP   = GAP_DEF,
  parameter int BA    = $clog2(((LEN_A > LEN_B) ? LEN_A : LEN_B) + 1),
  parameter int AW    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                init_start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                we_o,
  output logic [AW-1:0]       waddr_o,
  output logic signed [W-1:0] wdata_o
);

  localparam logic [31:0] ROW_LEN = 32'(LEN_A + 1);

  init_state_e         state_q, state_d;
  logic [BA-1:0]       k_q, k_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state: walk row 0 then column 0, advancing k and the penalty.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (init_start_i) begin
          state_d = ST_ROW;
          k_d     = '0;
          acc_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ROW: begin
        if (k_q == BA'(LEN_A)) begin
          // Column fill starts at k=1; (0,0) was written by the row pass.
          state_d = ST_COL;
          k_d     = BA'(1);
          acc_d   = W'(GAP);
        end else begin
          k_d   = k_q + BA'(1);
          acc_d = acc_q + W'(GAP);
        end
      end
      ST_COL: begin
        if (k_q == BA'(LEN_B)) begin
          state_d = ST_DONE;
        end else begin
          k_d   = k_q + BA'(1);
          acc_d = acc_q + W'(GAP);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ROW) || (state_d == ST_COL);
    done_d = (state_d == ST_DONE);
  end

  // State, counter, accumulator and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Write port: row pass addresses (k,0), column pass addresses (0,k).
  always_comb begin
    if (state_q == ST_ROW) begin
      waddr_o = AW'(cell_addr(32'(k_q), 32'd0, ROW_LEN));
    end else begin
      waddr_o = AW'(cell_addr(32'd0, 32'(k_q), ROW_LEN));
    end
  end

  assign we_o    = busy_q;
  assign wdata_o = acc_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/score_matrix_mem.sv
// ---------------------------------------------------------------------------
// score_matrix_mem
// Score matrix store for the Needleman-Wunsch datapath. (LEN_A+1)x(LEN_B+1)
// words of W-bit signed scores, row 0 / column 0 self-initialised with gap
// penalties. Serves a three-neighbour read for the cell engine, a write
// port for computed scores and a random-access traceback read.
// Optional macro: SCORE_FWD_EN -- forwards a same-cycle user write to any
// read output whose address matches.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   init_start/busy/done     gap fill control and status
//   wr_en, wr_i, wr_j, wr_data   write of cell (wr_i+1, wr_j+1)
//   rd_req, rd_i, rd_j       neighbour read for cell (rd_i+1, rd_j+1)
//   rd_valid, diag, up, left scores at (i,j), (i+1,j), (i,j+1), latency 1
//   tb_req, tb_x, tb_y       traceback read of absolute cell (x,y)
//   tb_valid, tb_data        traceback result, latency 1
//   addr_err                 sticky out-of-range flag, cleared by init_start
// ---------------------------------------------------------------------------
module score_matrix_mem
  import nw_pkg::*;
#(
  parameter int LEN_A = 128,
  parameter int LEN_B = 128,
  parameter int W     = W_DEF,
  parameter int GAP   = GAP_DEF,
  parameter int BA    = $clog2(((LEN_A > LEN_B) ? LEN_A : LEN_B) + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_start,
  output logic                init_busy,
  output logic                init_done,
  input  logic                wr_en,
  input  logic [BA-1:0]       wr_i,
  input  logic [BA-1:0]       wr_j,
  input  logic signed [W-1:0] wr_data,
  input  logic                rd_req,
  input  logic [BA-1:0]       rd_i,
  input  logic [BA-1:0]       rd_j,
  output logic                rd_valid,
  output logic signed [W-1:0] diag,
  output logic signed [W-1:0] up,
  output logic signed [W-1:0] left,
  input  logic                tb_req,
  input  logic [BA-1:0]       tb_x,
  input  logic [BA-1:0]       tb_y,
  output logic                tb_valid,
  output logic signed [W-1:0] tb_data,
  output logic                addr_err
);

  localparam int          DEPTH   = (LEN_A + 1) * (LEN_B + 1);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ROW_LEN = 32'(LEN_A + 1);

  logic signed [W-1:0] mem_q [DEPTH];

  logic                init_busy_s, init_done_s, init_we_s;
  logic [AW-1:0]       init_waddr_s;
  logic signed [W-1:0] init_wdata_s;

  logic                wr_ok_s, usr_we_s;
  logic [AW-1:0]       usr_waddr_s;
  logic                mem_we_s;
  logic [AW-1:0]       mem_waddr_s;
  logic signed [W-1:0] mem_wdata_s;

  logic                rd_ok_s, rd_acc_s, tb_ok_s, tb_acc_s, err_s;
  logic [AW-1:0]       diag_addr_s, up_addr_s, left_addr_s, tb_addr_s;
  logic signed [W-1:0] diag_rd_s, up_rd_s, left_rd_s, tb_rd_s;

  logic                rd_valid_q, rd_valid_d;
  logic                tb_valid_q, tb_valid_d;
  logic                addr_err_q, addr_err_d;
  logic signed [W-1:0] diag_q, diag_d, up_q, up_d, left_q, left_d;
  logic signed [W-1:0] tb_data_q, tb_data_d;

  score_init_seq #(
    .LEN_A (LEN_A),
    .LEN_B (LEN_B),
    .W     (W),
    .GAP   (GAP),
    .BA    (BA),
    .AW    (AW)
  ) u_init (
    .clk_i        (clk),
    .rst_ni       (rst),
    .init_start_i (init_start),
    .busy_o       (init_busy_s),
    .done_o       (init_done_s),
    .we_o         (init_we_s),
    .waddr_o      (init_waddr_s),
    .wdata_o      (init_wdata_s)
  );

  score_init_chk #(
    .LEN_A (LEN_A),
    .LEN_B (LEN_B),
    .W     (W),
    .GAP   (GAP)
  ) u_chk (
    .clk_i  (clk),
    .busy_i (init_busy_s)
  );

  // User write: 0-based string indices map to matrix cell (i+1, j+1).
  assign wr_ok_s     = (wr_i < BA'(LEN_A)) && (wr_j < BA'(LEN_B));
  assign usr_we_s    = wr_en && !init_busy_s && wr_ok_s;
  assign usr_waddr_s = AW'(cell_addr(32'(wr_i) + 32'd1, 32'(wr_j) + 32'd1, ROW_LEN));

  // The fill owns the write port while it runs; user writes are locked out.
  assign mem_we_s    = init_we_s || usr_we_s;
  assign mem_waddr_s = init_we_s ? init_waddr_s : usr_waddr_s;
  assign mem_wdata_s = init_we_s ? init_wdata_s : wr_data;

  // Read-side addressing and range checks.
  assign rd_ok_s     = (rd_i < BA'(LEN_A)) && (rd_j < BA'(LEN_B));
  assign rd_acc_s    = rd_req && !init_busy_s;
  assign diag_addr_s = AW'(cell_addr(32'(rd_i), 32'(rd_j), ROW_LEN));
  assign up_addr_s   = AW'(cell_addr(32'(rd_i) + 32'd1, 32'(rd_j), ROW_LEN));
  assign left_addr_s = AW'(cell_addr(32'(rd_i), 32'(rd_j) + 32'd1, ROW_LEN));

  assign tb_ok_s     = (tb_x <= BA'(LEN_A)) && (tb_y <= BA'(LEN_B));
  assign tb_acc_s    = tb_req && !init_busy_s;
  assign tb_addr_s   = AW'(cell_addr(32'(tb_x), 32'(tb_y), ROW_LEN));

`ifdef SCORE_FWD_EN
  // A same-cycle write to a read address is visible at the read output.
  assign diag_rd_s = (usr_we_s && (usr_waddr_s == diag_addr_s)) ? wr_data : mem_q[diag_addr_s];
  assign up_rd_s   = (usr_we_s && (usr_waddr_s == up_addr_s))   ? wr_data : mem_q[up_addr_s];
  assign left_rd_s = (usr_we_s && (usr_waddr_s == left_addr_s)) ? wr_data : mem_q[left_addr_s];
  assign tb_rd_s   = (usr_we_s && (usr_waddr_s == tb_addr_s))   ? wr_data : mem_q[tb_addr_s];
`else
  // Reads see pre-write contents; the controller spaces dependent accesses.
  assign diag_rd_s = mem_q[diag_addr_s];
  assign up_rd_s   = mem_q[up_addr_s];
  assign left_rd_s = mem_q[left_addr_s];
  assign tb_rd_s   = mem_q[tb_addr_s];
`endif

  assign err_s = (wr_en && !init_busy_s && !wr_ok_s)
              || (rd_acc_s && !rd_ok_s)
              || (tb_acc_s && !tb_ok_s);

  // Output next-state: load on an accepted request (0 when out of range),
  // otherwise hold the last value.
  always_comb begin
    rd_valid_d = rd_acc_s;
    tb_valid_d = tb_acc_s;
    if (rd_acc_s) begin
      if (rd_ok_s) begin
        diag_d = diag_rd_s;
        up_d   = up_rd_s;
        left_d = left_rd_s;
      end else begin
        diag_d = '0;
        up_d   = '0;
        left_d = '0;
      end
    end else begin
      diag_d = diag_q;
      up_d   = up_q;
      left_d = left_q;
    end
    if (tb_acc_s) begin
      if (tb_ok_s) begin
        tb_data_d = tb_rd_s;
      end else begin
        tb_data_d = '0;
      end
    end else begin
      tb_data_d = tb_data_q;
    end
    // An accepted init_start clears the flag; a same-cycle error still sets it.
    addr_err_d = err_s || (addr_err_q && !(init_start && !init_busy_s));
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      tb_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      diag_q     <= '0;
      up_q       <= '0;
      left_q     <= '0;
      tb_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      tb_valid_q <= tb_valid_d;
      addr_err_q <= addr_err_d;
      diag_q     <= diag_d;
      up_q       <= up_d;
      left_q     <= left_d;
      tb_data_q  <= tb_data_d;
    end
  end

  // Score storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign init_busy = init_busy_s;
  assign init_done = init_done_s;
  assign rd_valid  = rd_valid_q;
  assign tb_valid  = tb_valid_q;
  assign addr_err  = addr_err_q;
  assign diag      = diag_q;
  assign up        = up_q;
  assign left      = left_q;
  assign tb_data   = tb_data_q;

endmodule

// File: tb/tb_score_matrix_mem.sv
// ---------------------------------------------------------------------------
// tb_score_matrix_mem
// Directed bench for score_matrix_mem with LEN_A=4, LEN_B=3, W=9, GAP=-2.
// Read expectations are queued when a request is driven and compared when
// the matching valid pulse appears.
// ---------------------------------------------------------------------------
module tb_score_matrix_mem;

  localparam int LA  = 4;
  localparam int LB  = 3;
  localparam int WW  = 9;
  localparam int GP  = -2;
  localparam int BAW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           init_start;
  logic           init_busy, init_done;
  logic           wr_en;
  logic [BAW-1:0] wr_i, wr_j;
  logic [WW-1:0]  wr_data;
  logic           rd_req;
  logic [BAW-1:0] rd_i, rd_j;
  logic           rd_valid;
  logic [WW-1:0]  diag, up, left;
  logic           tb_req;
  logic [BAW-1:0] tb_x, tb_y;
  logic           tb_valid;
  logic [WW-1:0]  tb_data;
  logic           addr_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3*WW-1:0] nb_exp_q [$];
  logic [WW-1:0]   tb_exp_q [$];
  logic [3*WW-1:0] nb_e;
  logic [WW-1:0]   tb_e;
  logic [WW-1:0]   c11;
  int              n;

  always #5 clk = ~clk;

  score_matrix_mem #(
    .LEN_A (LA),
    .LEN_B (LB),
    .W     (WW),
    .GAP   (GP),
    .BA    (BAW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .wr_en      (wr_en),
    .wr_i       (wr_i),
    .wr_j       (wr_j),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .rd_i       (rd_i),
    .rd_j       (rd_j),
    .rd_valid   (rd_valid),
    .diag       (diag),
    .up         (up),
    .left       (left),
    .tb_req     (tb_req),
    .tb_x       (tb_x),
    .tb_y       (tb_y),
    .tb_valid   (tb_valid),
    .tb_data    (tb_data),
    .addr_err   (addr_err)
  );

  function automatic logic [WW-1:0] sc(input int v);
    return v[WW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_wr(input int i, input int j, input int d);
    wr_en = 1'b1; wr_i = BAW'(i); wr_j = BAW'(j); wr_data = sc(d);
  endtask

  task automatic set_rd(input int i, input int j, input int d, input int u, input int l);
    rd_req = 1'b1; rd_i = BAW'(i); rd_j = BAW'(j);
    nb_exp_q.push_back({sc(d), sc(u), sc(l)});
  endtask

  task automatic set_tb(input int x, input int y, input int e);
    tb_req = 1'b1; tb_x = BAW'(x); tb_y = BAW'(y);
    tb_exp_q.push_back(sc(e));
  endtask

  // Advance one cycle, then drop all single-cycle requests.
  task automatic step();
    @(negedge clk);
    wr_en = 1'b0; rd_req = 1'b0; tb_req = 1'b0; init_start = 1'b0;
  endtask

  // Pulse init_start and count cycles with init_busy high (bounded).
  task automatic fill(output int cnt);
    init_start = 1'b1;
    step();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (init_busy !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rd_valid === 1'b1) begin
        if (nb_exp_q.size() == 0) begin
          chk("nb_unexpected_valid", 32'(rd_valid), 32'd0);
        end else begin
          nb_e = nb_exp_q.pop_front();
          chk("nb_diag", 32'(diag), 32'(nb_e[3*WW-1:2*WW]));
          chk("nb_up",   32'(up),   32'(nb_e[2*WW-1:WW]));
          chk("nb_left", 32'(left), 32'(nb_e[WW-1:0]));
        end
      end
      if (tb_valid === 1'b1) begin
        if (tb_exp_q.size() == 0) begin
          chk("tb_unexpected_valid", 32'(tb_valid), 32'd0);
        end else begin
          tb_e = tb_exp_q.pop_front();
          chk("tb_data", 32'(tb_data), 32'(tb_e));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; init_start = 1'b0;
    wr_en = 1'b0; wr_i = '0; wr_j = '0; wr_data = '0;
    rd_req = 1'b0; rd_i = '0; rd_j = '0;
    tb_req = 1'b0; tb_x = '0; tb_y = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(init_busy), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_tb_valid", 32'(tb_valid), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_data", 32'({diag, up, left, tb_data}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Gap fill: 8 busy cycles, then row 0 / column 0 via traceback port
    fill(n);
    chk("fill_cycles", 32'(n), 32'd8);
    chk("fill_done", 32'(init_done), 32'd1);
    for (int x = 0; x <= LA; x++) begin
      set_tb(x, 0, x * GP);
      step();
    end
    for (int y = 1; y <= LB; y++) begin
      set_tb(0, y, y * GP);
      step();
    end
    @(negedge clk);

    // Neighbour reads
    set_wr(0, 0, 5); c11 = sc(5);
    step();
    set_rd(1, 0, -2, -4, 5);
    step();
    set_wr(1, 0, 3);
    step();
    set_rd(2, 0, -4, -6, 3);
    step();
    set_rd(0, 0, 0, -2, -2);
    set_tb(1, 1, 5);
    step();
    @(negedge clk);

    // Same-cycle write and read
`ifdef SCORE_FWD_EN
    set_wr(0, 0, 7); set_rd(1, 0, -2, -4, 7);
    step();
    set_wr(0, 0, 9); set_tb(1, 1, 9);
    step();
`else
    set_wr(0, 0, 7); set_rd(1, 0, -2, -4, 5);
    step();
    set_wr(0, 0, 9); set_tb(1, 1, 7);
    step();
`endif
    c11 = sc(9);
    set_rd(1, 0, -2, -4, 9);
    step();
    @(negedge clk);

    // Range checks
    chk("err_clear_before", 32'(addr_err), 32'd0);
    set_wr(4, 0, 55);
    step();
    chk("wr_oob_err", 32'(addr_err), 32'd1);
    set_tb(5, 0, 0);
    set_rd(4, 0, 0, 0, 0);
    step();
    set_rd(0, 3, 0, 0, 0);
    step();
    @(negedge clk);
    fill(n);
    chk("refill_cycles", 32'(n), 32'd8);
    chk("init_clears_err", 32'(addr_err), 32'd0);
    set_tb(0, 2, -4);          // an out-of-range write to (5,1) would land here
    step();
    set_rd(1, 0, -2, -4, 9);
    step();
    @(negedge clk);

    // Reset during fill
    init_start = 1'b1;
    step();
    repeat (2) @(negedge clk);
    chk("midfill_busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(init_busy), 32'd0);
    chk("arst_done", 32'(init_done), 32'd0);
    chk("arst_valids", 32'({rd_valid, tb_valid, addr_err}), 32'd0);
    chk("arst_data", 32'({diag, up, left, tb_data}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(init_done), 32'd0);
    fill(n);
    chk("restart_cycles", 32'(n), 32'd8);
    chk("restart_done", 32'(init_done), 32'd1);

    // Busy lockout
    init_start = 1'b1;
    step();
    set_wr(0, 0, 99);
    rd_req = 1'b1; rd_i = '0; rd_j = '0;
    step();
    chk("lockout_no_valid", 32'(rd_valid), 32'd0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (init_busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    chk("lockout_fill_ends", 32'(init_busy), 32'd0);
    set_tb(1, 1, int'(signed'(c11)));
    step();
    @(negedge clk);

    chk("nb_queue_empty", 32'(nb_exp_q.size()), 32'd0);
    chk("tb_queue_empty", 32'(tb_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/score_matrix_mem.md
# score_matrix_mem

Parametrised score-matrix store for the Needleman-Wunsch datapath, sized for two independent sequence lengths and a configurable score width. It self-initialises the gap row and column from a `GAP` parameter and serves the three-neighbour read for the cell engine. It also provides a write port for computed scores and a separate random-access read port for the traceback stage. It sits between the control FSM, the max/score unit and the traceback unit.

## Interface
- `LEN_A`, default 128: length of string A (columns); matrix width is `LEN_A+1`.
- `LEN_B`, default 128: length of string B (rows); matrix height is `LEN_B+1`.
- `W`, default 9: score width, signed two's complement.
- `GAP`, default -1: signed gap penalty used for initialisation.
- `BA`, default `$clog2(max(LEN_A,LEN_B)+1)`: coordinate width.
- `clk`  input  1  clock; one clock, all logic on rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `init_start`  input  1  pulse that starts the gap row/column fill.
- `init_busy`  output  1  high while the fill is running.
- `init_done`  output  1  high from the end of the fill until the next `init_start` or reset.
- `wr_en`  input  1  writes `wr_data` to cell (`wr_i`+1, `wr_j`+1).
- `wr_i`, `wr_j`  input  BA  0-based string indices of the cell being written.
- `wr_data`  input  W  signed score.
- `rd_req`  input  1  neighbour read request for cell (`rd_i`+1, `rd_j`+1).
- `rd_i`, `rd_j`  input  BA  0-based string indices.
- `rd_valid`  output  1  one-cycle pulse qualifying `diag`/`up`/`left`.
- `diag`, `up`, `left`  output  W  scores at (i,j), (i+1,j) and (i,j+1) respectively.
- `tb_req`  input  1  traceback read request.
- `tb_x`, `tb_y`  input  BA  absolute cell coordinates, 0..LEN_A and 0..LEN_B.
- `tb_valid`  output  1  one-cycle pulse qualifying `tb_data`.
- `tb_data`  output  W  score at (`tb_x`, `tb_y`).
- `addr_err`  output  1  sticky out-of-range flag.

## Operation
- Storage: `(LEN_A+1)*(LEN_B+1)` words of W bits.
- Linear address of cell (x,y) is `x + (LEN_A+1)*y`.
- Contents are not cleared by reset.
- Init FSM states and transitions:
  - IDLE: `init_start` -> ROW.
  - ROW: writes cell (k,0) = k*GAP for k = 0..LEN_A, one cell per cycle -> COL.
  - COL: writes cell (0,k) = k*GAP for k = 1..LEN_B, one cell per cycle -> DONE.
  - DONE: holds; `init_start` -> ROW.
- The penalty is produced by a running W-bit accumulator: add `GAP` each cycle, no multiplier.
- Overflow wraps. A simulation-time assertion fires if `max(LEN_A,LEN_B)*|GAP|` does not fit in W signed bits.
- `init_start` while busy is ignored.
- `init_start` clears `init_done` and `addr_err`.
- While `init_busy` is high, `wr_en`, `rd_req` and `tb_req` are ignored: no write, no valid pulse.
- Write range check: requires `wr_i` < LEN_A and `wr_j` < LEN_B. On violation, the write is dropped and `addr_err` is set.
- Neighbour read range check: the same bounds apply to `rd_i`/`rd_j`. On violation, `rd_valid` still pulses, data is 0 and `addr_err` is set.
- Traceback read range check: requires `tb_x` ≤ LEN_A and `tb_y` ≤ LEN_B. On violation, handled the same way as a neighbour read.
- `rd_req` and `tb_req` in the same cycle are both served, since reads are independent.
- Write and read in the same cycle: the write commits at the edge. Read data reflects pre-write contents unless `SCORE_FWD_EN` is defined (see Configuration).

## Timing
- Reset values of all outputs: `init_busy`=0, `init_done`=0, `rd_valid`=0, `tb_valid`=0, `addr_err`=0, `diag`/`up`/`left`/`tb_data`=0. FSM returns to IDLE.
- Fill duration: `init_start` sampled at edge t -> `init_busy` high from t+1.
  - The first write (0,0) happens at t+1.
  - The last write happens at t+LEN_A+LEN_B+1.
  - At t+LEN_A+LEN_B+2, `init_busy` is 0 and `init_done` is 1.
- Read latency is 1 for both ports: request at edge t -> data registered and valid pulse high in cycle t+1.
- Back-to-back requests give one result per cycle.
- Data outputs hold their last value when no valid pulse is present.
- Reset asserted mid-fill aborts immediately. Partially written cells keep their values; `init_done` stays 0.

## Configuration
- `SCORE_FWD_EN` defined:
  - A same-cycle write whose address equals any read address (`diag`, `up`, `left` or `tb`) forwards `wr_data` to that output.
  - The cell engine can therefore issue the read for cell (i+1,j) in the same cycle as the write of (i,j).
- `SCORE_FWD_EN` undefined: no bypass. Same-cycle reads return the old contents, and the controller must insert one gap cycle.

## Structure
- Shared package `nw_pkg`:
  - score width `W` default;
  - `GAP` default;
  - init FSM state enum (IDLE/ROW/COL/DONE);
  - coordinate-to-linear-address function.
- Sub-module `score_init_seq`: the init FSM, the k counter and the penalty accumulator. It outputs write enable, address and data, which are muxed into the memory write port ahead of `wr_*`.

## Test plan
All scenarios use LEN_A=4, LEN_B=3, W=9, GAP=-2 unless noted.
- Init: pulse `init_start` -> `init_busy` high exactly 8 cycles. Traceback reads then return row 0 = 0,-2,-4,-6,-8 and column 0 = 0,-2,-4,-6; `init_done`=1.
- Neighbour read: write (i=0,j=0) = 5, then `rd_req` i=1,j=0 -> next cycle `rd_valid`=1, `diag`=-2, `up`=-4, `left`=5.
- Forwarding, with `SCORE_FWD_EN`: same-cycle write (0,0)=7 and `rd_req` (1,0) -> `left`=7. Without the macro -> `left` holds the old value.
- Range: `wr_en` with `wr_i`=4 -> no write and `addr_err`=1. `tb_req` (5,0) -> `tb_valid`=1, `tb_data`=0. `init_start` clears `addr_err`.
- Reset during fill: assert `rst`=0 at fill cycle 3 -> all outputs 0 and FSM IDLE. A re-start then completes normally in 8 cycles.
- Busy lockout: `rd_req` and `wr_en` during fill -> no `rd_valid` pulse and the written cell is unchanged.
